// File: rtl/mips_multicycle_ctrl_if.sv
// Memory-side handshake between the multi-cycle sequencer and the shared
// instruction/data memory.
interface mips_multicycle_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps each instruction through fetch/decode/
// execute/memory/writeback, with a memory-ready watchdog and illegal-opcode trap.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [5:0]          opcode,
  mips_multicycle_ctrl_if.master mem,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [3:0]          state,
  output logic                busy,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd15
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

  state_t                state_q, state_d;
  logic [1:0]            trap_q, trap_d;
  logic [CW-1:0]         wait_q;
  logic [RETIRE_W-1:0]   retired_q;
  logic                  retire;
  logic                  timeout;
  logic                  wait_state;
  logic                  mem_read_c, mem_write_c, i_or_d_c;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // Expires on the cycle the count would reach MEM_TIMEOUT; a ready in that cycle still wins.
  assign timeout    = (MEM_TIMEOUT > 0) && !mem.mem_ready && (wait_q == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      trap_q    <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (wait_state && !mem.mem_ready && wait_q != '1)
        wait_q <= wait_q + CW'(1);
      if (retire && retired_q != '1)
        retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH, S_MEM_READ: begin
        if (mem.mem_ready)
          state_d = (state_q == S_FETCH) ? S_DECODE : S_MEM_WB;
        else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = 2'b10;
        end
      end
      S_DECODE: begin
        case (opcode)
          6'h00:        state_d = S_R_EXEC;
          6'h23, 6'h2B: state_d = S_MEM_ADDR;
          6'h04:        state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          6'h08:        state_d = S_ADDI_EXEC;
          default: begin
            state_d = S_TRAP;
            trap_d  = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_WRITE: begin
        if (mem.mem_ready) begin
          state_d = run ? S_FETCH : S_IDLE;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = 2'b10;
        end
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = run ? S_FETCH : S_IDLE;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d_c      = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem.mem_ready;
        pc_write   = mem.mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_read  = mem_read_c;
  assign mem.mem_write = mem_write_c;
  assign mem.i_or_d    = i_or_d_c;
  assign state         = state_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap_cause    = trap_q;
  assign retired       = retired_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback, and drives the per-cycle datapath selects and enables. It handles variable-latency memory through a ready handshake, watchdogs that handshake, and traps on illegal opcodes. It sits beside the register file, ALU, ALU control unit and the shared instruction/data memory.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready cycles in one memory state before a timeout trap; 0 disables the watchdog.
RETIRE_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
run  input  1  permits starting the next instruction
opcode  input  6  IR[31:26] from the datapath, valid from DECODE onward
mem_ready  input  1  memory has completed the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  memory address select: 0=PC, 1=ALU out
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  writeback select: 0=ALU out, 1=memory data
reg_dst  output  1  destination select: 0=rt, 1=rd
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=rs data
alu_src_b  output  2  00=rt data, 01=constant 1, 10=sign-extended immediate, 11=immediate used as branch offset
alu_op  output  2  00=add, 01=subtract, 10=use funct
pc_source  output  2  00=ALU result, 01=ALU out register, 10=jump target
state  output  4  current state encoding
busy  output  1  high when state is neither IDLE nor TRAP
trap_cause  output  2  00=none, 01=illegal opcode, 10=memory timeout
retired  output  RETIRE_W  count of completed instructions

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=15. Codes 13 and 14 are unreachable and return to IDLE.
- Reset (rst=0, at any time, including mid-instruction or mid-wait):
  - state=IDLE, trap_cause=00, retired=0, wait counter=0.
  - All control outputs are 0.
- Outputs are Moore, decoded from state. Every control not listed for a state is 0.
- Per-state outputs:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are asserted only in the cycle where mem_ready=1 (Mealy exception).
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEM_ADDR and ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- Transitions:
  - IDLE: to FETCH if run=1, otherwise stay.
  - FETCH, MEM_READ, MEM_WRITE: hold while mem_ready=0; advance on mem_ready=1. FETCH goes to DECODE, MEM_READ to MEM_WB.
  - DECODE, by opcode:
    - 0x00 -> R_EXEC
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDI_EXEC
    - any other value -> TRAP with trap_cause=01
  - MEM_ADDR: to MEM_READ if opcode=0x23, else to MEM_WRITE.
  - R_EXEC -> R_WB; ADDI_EXEC -> ADDI_WB.
  - Terminal states (MEM_WB, MEM_WRITE on ready, R_WB, BRANCH, JUMP, ADDI_WB): go to FETCH if run=1, else IDLE.
  - TRAP is sticky. Only reset exits it. All control outputs are 0 in TRAP.
- Retire counter:
  - Increments by 1 on each exit from a terminal state.
  - Saturates at all-ones.
  - Never increments on entry to TRAP.
- Watchdog (MEM_TIMEOUT>0):
  - The wait counter clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - It increments each cycle mem_ready=0 in those states.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with trap_cause=10.
  - If mem_ready=1 arrives in the same cycle the count would expire, mem_ready wins and the state advances.
- Latency with mem_ready tied to 1, from FETCH entry:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
- The opcode input is sampled only in DECODE and MEM_ADDR.

Test Plan:
- Reset then run=1, mem_ready=1, opcode=0x00 -> states 1,2,7,8,1; reg_dst=1 and reg_write=1 only in state 8; retired=1 after 4 cycles.
- opcode=0x23, mem_ready low for 3 cycles in MEM_READ -> mem_read and i_or_d held 3 extra cycles; reg_write=1 with mem_to_reg=1 once; lw total 8 cycles.
- opcode=0x3F in DECODE -> state=15, trap_cause=01, all controls 0; run and mem_ready ignored until rst=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with trap_cause=10 after the 4th wait cycle; ir_write never asserted.
- rst pulsed low in the middle of MEM_WRITE -> outputs go to 0 immediately with no clock; state=0, retired=0.
- Back-to-back beq then j with run dropped during JUMP -> pc_write_cond=1 in state 9, pc_write=1 with pc_source=10 in state 10, next state IDLE, retired=2.
